io_sequencer: RTL and testbench
===============================

IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a new key level.
REQ-002 SHALL have parameter OUT_HOLD_CYCLES, default 8: cycles an output value is shown before acknowledgment.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port io_req, input, 1 bit: CPU requests an IO operation; held until io_ack.
REQ-006 SHALL have port io_dir, input, 1 bit: 1 = input operation, 0 = output operation; sampled with io_req in IDLE.
REQ-007 SHALL have port io_wdata, input, 32 bits: value to display for an output operation.
REQ-008 SHALL have port confirm_key, input, 1 bit: raw asynchronous pushbutton, active-low (0 = pressed).
REQ-009 SHALL have port sw_data, input, 32 bits: switch value from the display/switch IO block.
REQ-010 SHALL have port cpu_stall, output, 1 bit: freezes the CPU while an operation is pending.
REQ-011 SHALL have port io_ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port io_rdata, output, 32 bits: captured switch value.
REQ-013 SHALL have port num, output, 32 bits: value driven to the display block.
REQ-014 SHALL have port output_flag, output, 1 bit: display shows num.
REQ-015 SHALL have port input_flag, output, 1 bit: display shows live switch input.

Function
REQ-016 SHALL pass confirm_key through a 2-flop synchronizer; debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-017 SHALL define press as debounced 1->0 and release as debounced 0->1; each is a single-cycle internal event.
REQ-018 SHALL implement states IDLE, IN_WAIT, IN_RELEASE, OUT_HOLD, ACK.
REQ-019 IDLE: io_req=1 and io_dir=1 -> IN_WAIT; io_req=1 and io_dir=0 -> OUT_HOLD, with num<=io_wdata and hold counter cleared; otherwise stay.
REQ-020 IN_WAIT: input_flag=1, output_flag=0; on a press, io_rdata<=sw_data in that cycle, then -> IN_RELEASE.
REQ-021 IN_RELEASE: input_flag=1; on a release -> ACK.
REQ-022 OUT_HOLD: output_flag=1, input_flag=0; counter increments each cycle; -> ACK after exactly OUT_HOLD_CYCLES cycles in OUT_HOLD.
REQ-023 ACK: io_ack=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-024 cpu_stall SHALL be combinational: io_req AND NOT io_ack.
REQ-025 After an output completes, output_flag and num SHALL stay unchanged until the next request leaves IDLE; after an input completes, input_flag=0, output_flag=0.
REQ-026 A key already held when IN_WAIT is entered SHALL NOT count; it must be released and pressed again.
REQ-027 Presses in IDLE, OUT_HOLD or ACK SHALL be ignored and SHALL NOT be queued.
REQ-028 If io_req deasserts mid-operation, the operation SHALL still complete and pulse io_ack.
REQ-029 io_req sampled in the ACK cycle SHALL NOT start a new operation; a new operation starts at the earliest from IDLE on the following cycle.
REQ-030 io_rdata SHALL hold its value until the next capture.
REQ-031 Key bounce shorter than DEBOUNCE_CYCLES SHALL produce no press or release event.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE and clear the counters and synchronizer.
REQ-033 During reset, all outputs SHALL be 0: io_ack, cpu_stall, io_rdata, num, output_flag, input_flag.
REQ-034 During reset, the debounced key level SHALL be 1 (released).
REQ-035 Reset asserted mid-operation SHALL abort the operation with no io_ack.

Verification (DEBOUNCE_CYCLES=4, OUT_HOLD_CYCLES=3)
REQ-036 Scenario 1: output request with io_wdata=1234 -> num=1234 and output_flag=1 from the next cycle; io_ack pulses after 3 OUT_HOLD cycles; num=1234 persists in IDLE.
REQ-037 Scenario 2: input request with sw_data=0x1A5; key low 10 cycles, then high -> io_rdata=0x1A5 captured on the press event; io_ack follows the debounced release; input_flag=0 afterwards.
REQ-038 Scenario 3: key toggling every 2 cycles for 20 cycles during IN_WAIT -> no capture and no io_ack; a following clean press completes normally.
REQ-039 Scenario 4: key held low before an input request -> no capture until release plus a new press.
REQ-040 Scenario 5: reset=0 during OUT_HOLD with num=77 -> all outputs 0 next cycle, no io_ack; a new request after reset completes normally.
REQ-041 Scenario 6: io_req held high through ACK -> exactly one io_ack; the second operation begins from IDLE one cycle after ACK.

Source files
------------

// File: rtl/io_sequencer.sv
// io_sequencer: holds the CPU stalled across one IO operation. Inputs complete on a
// debounced press/release of the confirm key; outputs are shown for a fixed hold time.
module io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req,
  input  logic        io_dir,
  input  logic [31:0] io_wdata,
  input  logic        confirm_key,
  input  logic [31:0] sw_data,
  output logic        cpu_stall,
  output logic        io_ack,
  output logic [31:0] io_rdata,
  output logic [31:0] num,
  output logic        output_flag,
  output logic        input_flag
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(OUT_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, IN_WAIT, IN_RELEASE, OUT_HOLD, ACK} state_t;

  state_t            state;
  logic              key_p0;
  logic              key_p1;
  logic              key_deb;
  logic [DB_W-1:0]   db_cnt;
  logic              key_press;
  logic              key_release;
  logic [HOLD_W-1:0] hold_cnt;

  // Reset gates the stall so every output reads 0 while reset is held.
  assign cpu_stall = reset & io_req & ~io_ack;

  // Synchronizer and debouncer. The flops reset to the released level (1) so a
  // key that is idle at reset release never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_p0      <= 1'b1;
      key_p1      <= 1'b1;
      key_deb     <= 1'b1;
      db_cnt      <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_p0      <= confirm_key;
      key_p1      <= key_p0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (key_p1 == key_deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_deb     <= key_p1;
        db_cnt      <= '0;
        key_press   <= ~key_p1;
        key_release <= key_p1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Operation sequencer; events are only looked at in the state that wants them,
  // so presses elsewhere are simply dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      io_ack      <= 1'b0;
      io_rdata    <= '0;
      num         <= '0;
      output_flag <= 1'b0;
      input_flag  <= 1'b0;
    end else begin
      io_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (io_req) begin
            if (io_dir) begin
              state       <= IN_WAIT;
              input_flag  <= 1'b1;
              output_flag <= 1'b0;
            end else begin
              state       <= OUT_HOLD;
              num         <= io_wdata;
              hold_cnt    <= '0;
              output_flag <= 1'b1;
              input_flag  <= 1'b0;
            end
          end
        end
        IN_WAIT: begin
          if (key_press) begin
            io_rdata <= sw_data;
            state    <= IN_RELEASE;
          end
        end
        IN_RELEASE: begin
          if (key_release) begin
            state      <= ACK;
            io_ack     <= 1'b1;
            input_flag <= 1'b0;
          end
        end
        OUT_HOLD: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_W'(OUT_HOLD_CYCLES - 1)) begin
            state  <= ACK;
            io_ack <= 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed scenarios plus randomized key/operation traffic,
// checked against a debounce/transaction reference model.
module tb_io_sequencer;
  localparam int DB   = 4;
  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req;
  logic        io_dir;
  logic [31:0] io_wdata;
  logic        confirm_key;
  logic [31:0] sw_data;
  logic        cpu_stall;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic [31:0] num;
  logic        output_flag;
  logic        input_flag;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: raw key history, debounced level and its edges.
  bit          hist[$];
  bit          plan[$];
  bit          m_deb;
  bit          m_fall;
  bit          m_rise;
  logic [31:0] m_rdata;

  io_sequencer #(.DEBOUNCE_CYCLES(DB), .OUT_HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
    .confirm_key(confirm_key), .sw_data(sw_data), .cpu_stall(cpu_stall), .io_ack(io_ack),
    .io_rdata(io_rdata), .num(num), .output_flag(output_flag), .input_flag(input_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock: the key level changes once DB consecutive synchronized samples
  // (key delayed by two clocks) agree; reset restores the released level.
  task automatic tick();
    bit all0, all1;
    @(posedge clk);
    if (!reset) begin
      hist.delete();
      repeat (DB + 2) hist.push_back(1'b1);
      m_deb   = 1'b1;
      m_fall  = 1'b0;
      m_rise  = 1'b0;
      m_rdata = '0;
    end else begin
      hist.push_back(confirm_key);
      void'(hist.pop_front());
      all0 = 1'b1;
      all1 = 1'b1;
      for (int i = 0; i < DB; i++) begin
        if (hist[i]) all0 = 1'b0;
        else         all1 = 1'b0;
      end
      m_fall = m_deb && all0;
      m_rise = !m_deb && all1;
      if (all0) m_deb = 1'b0;
      if (all1) m_deb = 1'b1;
    end
    #1;
    confirm_key = (plan.size() > 0) ? plan.pop_front() : 1'b1;
  endtask

  task automatic idle_tick();
    tick();
    chkb("idle_ack", io_ack, 1'b0);
    chk("idle_rdata", io_rdata, m_rdata);
  endtask

  task automatic drain();
    while (plan.size() > 0) idle_tick();
    repeat (DB + 4) idle_tick();
  endtask

  task automatic push_bounce();
    int runs;
    int len;
    bit lvl;
    runs = $urandom_range(0, 4);
    lvl  = 1'b0;
    for (int i = 0; i < runs; i++) begin
      len = $urandom_range(1, DB - 1);
      for (int j = 0; j < len; j++) plan.push_back(lvl);
      lvl = ~lvl;
    end
  endtask

  task automatic run_output(input logic [31:0] w, input bit keep_req);
    io_req   = 1'b1;
    io_dir   = 1'b0;
    io_wdata = w;
    tick();
    chk("out_num", num, w);
    chkb("out_flag", output_flag, 1'b1);
    chkb("out_inflag", input_flag, 1'b0);
    chkb("out_ack_early", io_ack, 1'b0);
    chkb("out_stall", cpu_stall, 1'b1);
    for (int k = 1; k <= HOLD; k++) begin
      io_wdata = $urandom;
      tick();
      chkb("out_ack", io_ack, k == HOLD);
      chk("out_num_hold", num, w);
      chkb("out_stall_hold", cpu_stall, k != HOLD);
    end
    if (!keep_req) io_req = 1'b0;
    io_wdata = $urandom;
    tick();
    chkb("out_ack_once", io_ack, 1'b0);
    chk("out_num_keep", num, w);
    chkb("out_flag_keep", output_flag, 1'b1);
    chk("out_rdata", io_rdata, m_rdata);
  endtask

  task automatic run_input(input logic [31:0] sw0, input bit rand_sw, input int budget);
    logic [31:0] exp_rd;
    logic [31:0] sw_edge;
    bit fell, captured, rose, done;
    int n;
    exp_rd   = m_rdata;
    captured = 1'b0;
    rose     = 1'b0;
    done     = 1'b0;
    n        = 0;
    io_req   = 1'b1;
    io_dir   = 1'b1;
    sw_data  = sw0;
    tick();
    fell = m_fall;
    chkb("in_flag", input_flag, 1'b1);
    chkb("in_outflag", output_flag, 1'b0);
    chkb("in_stall", cpu_stall, 1'b1);
    while (!done && n < budget) begin
      if (rand_sw) sw_data = $urandom;
      sw_edge = sw_data;
      tick();
      n++;
      if (rose) begin
        done = 1'b1;
      end else if (fell && !captured) begin
        captured = 1'b1;
        exp_rd   = sw_edge;
      end else if (captured && m_rise) begin
        rose = 1'b1;
      end else if (!captured && m_fall) begin
        fell = 1'b1;
      end
      chkb("in_ack", io_ack, done);
      chkb("in_flag_live", input_flag, !done);
      chkb("in_stall_live", cpu_stall, !done);
      chk("in_rdata", io_rdata, exp_rd);
    end
    chkb("in_done", done, 1'b1);
    m_rdata = exp_rd;
    io_req  = 1'b0;
    tick();
    chkb("in_ack_once", io_ack, 1'b0);
    chkb("in_flag_off", input_flag, 1'b0);
    chkb("in_outflag_off", output_flag, 1'b0);
    chk("in_rdata_keep", io_rdata, m_rdata);
  endtask

  initial begin
    reset       = 1'b0;
    io_req      = 1'b1;
    io_dir      = 1'b0;
    io_wdata    = 32'hdead_beef;
    sw_data     = 32'h0;
    confirm_key = 1'b1;
    m_rdata     = '0;
    repeat (3) tick();
    chkb("rst_ack", io_ack, 1'b0);
    chkb("rst_stall", cpu_stall, 1'b0);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_num", num, 32'd0);
    chkb("rst_outflag", output_flag, 1'b0);
    chkb("rst_inflag", input_flag, 1'b0);
    io_req = 1'b0;
    reset  = 1'b1;
    drain();

    // Scenario 1: output 1234
    run_output(32'd1234, 1'b0);
    repeat (3) idle_tick();
    chk("s1_num_idle", num, 32'd1234);
    chkb("s1_flag_idle", output_flag, 1'b1);

    // Scenario 2: input 0x1A5, key low 10 cycles
    repeat (10) plan.push_back(1'b0);
    run_input(32'h1A5, 1'b0, 100);
    chk("s2_rdata", io_rdata, 32'h1A5);
    drain();

    // Scenario 3: bounce every 2 cycles for 20 cycles, then a clean press
    for (int i = 0; i < 5; i++) begin
      plan.push_back(1'b0); plan.push_back(1'b0);
      plan.push_back(1'b1); plan.push_back(1'b1);
    end
    repeat (8) plan.push_back(1'b0);
    run_input($urandom, 1'b1, 200);
    drain();

    // Scenario 4: key already held when the request arrives
    repeat (10) plan.push_back(1'b0);
    repeat (8) idle_tick();
    repeat (6) plan.push_back(1'b0);
    repeat (8) plan.push_back(1'b1);
    repeat (8) plan.push_back(1'b0);
    run_input($urandom, 1'b1, 200);
    drain();

    // Scenario 5: reset during OUT_HOLD aborts without an ack
    io_req   = 1'b1;
    io_dir   = 1'b0;
    io_wdata = 32'd77;
    tick();
    chk("s5_num", num, 32'd77);
    tick();
    reset = 1'b0;
    tick();
    chkb("s5_ack", io_ack, 1'b0);
    chkb("s5_stall", cpu_stall, 1'b0);
    chk("s5_num_clr", num, 32'd0);
    chk("s5_rdata_clr", io_rdata, 32'd0);
    chkb("s5_outflag", output_flag, 1'b0);
    chkb("s5_inflag", input_flag, 1'b0);
    tick();
    chkb("s5_ack_hold", io_ack, 1'b0);
    reset  = 1'b1;
    io_req = 1'b0;
    repeat (6) idle_tick();
    chk("s5_num_after", num, 32'd0);
    run_output($urandom, 1'b0);
    drain();

    // Scenario 6: request held through ACK gives one ack, next op from IDLE
    run_output(32'h0000_5a5a, 1'b1);
    run_output(32'h0000_a5a5, 1'b0);
    drain();

    // Randomized traffic, with stray presses during output operations
    for (int op = 0; op < 14; op++) begin
      if ($urandom_range(0, 1) == 1) begin
        push_bounce();
        repeat ($urandom_range(DB, 3 * DB)) plan.push_back(1'b0);
        push_bounce();
        repeat (DB + 2) plan.push_back(1'b1);
        run_input($urandom, 1'b1, 300);
      end else begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(DB, 8)) plan.push_back(1'b0);
        run_output($urandom, 1'b0);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
